// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, reset/NOP constants, IF/ID payload.
package mips_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned JUMP_IDX_W = 26;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
    localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus4;
        logic               valid;
    } ifid_t;

    // Next-PC source, in ascending priority
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_BRANCH = 2'd3
    } pc_sel_e;

    // J-type target: upper nibble of the jump's PC+4, index, word aligned
    function automatic logic [ADDR_W-1:0] jump_target(
        input logic [3:0]            pc_hi,
        input logic [JUMP_IDX_W-1:0] idx
    );
        return {pc_hi, idx, 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: redirect/stall controls and imem read data in,
// fetch address, PC, IF/ID contents and status out.
// slave  = fetch stage side, master = surrounding pipeline / memory side.
interface if_fetch_stage_if
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic                  BranchTaken;
    logic [ADDR_W-1:0]     BranchTarget;
    logic                  Jump;
    logic [JUMP_IDX_W-1:0] JumpIndex;
    logic                  Stall;
    logic [INSTR_W-1:0]    ImemRdata;
    logic [ADDR_W-1:0]     ImemAddr;
    logic [ADDR_W-1:0]     PC;
    logic [INSTR_W-1:0]    IfIdInstr;
    logic [ADDR_W-1:0]     IfIdPcPlus4;
    logic                  IfIdValid;
    logic                  Misaligned;
    logic [CNT_W-1:0]      RedirectCount;

    modport slave (
        input  BranchTaken, BranchTarget, Jump, JumpIndex, Stall, ImemRdata,
        output ImemAddr, PC, IfIdInstr, IfIdPcPlus4, IfIdValid, Misaligned,
        output RedirectCount
    );

    modport master (
        output BranchTaken, BranchTarget, Jump, JumpIndex, Stall, ImemRdata,
        input  ImemAddr, PC, IfIdInstr, IfIdPcPlus4, IfIdValid, Misaligned,
        input  RedirectCount
    );
endinterface

// File: rtl/next_pc_mux.sv
// Combinational next-PC priority select: branch > jump > stall > sequential.
// Ports:
//   i_pc, i_pc_plus4        current PC and PC+4
//   i_branch_taken/target   EX/MEM branch decision and target[31:2]
//   i_jump, i_jump_index    ID jump request and instr[25:0]
//   i_ifid_pc_hi            IfIdPcPlus4[31:28] of the jump in ID
//   i_stall                 hazard-unit stall
//   o_next_pc_c             PC value for the next edge
//   o_redirect_c            branch or jump taken this cycle
//   o_flush_c               IF/ID must be squashed
//   o_hold_c                IF/ID must hold
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0]     i_pc,
    input  logic [ADDR_W-1:0]     i_pc_plus4,
    input  logic                  i_branch_taken,
    input  logic [ADDR_W-1:2]     i_branch_target,
    input  logic                  i_jump,
    input  logic [JUMP_IDX_W-1:0] i_jump_index,
    input  logic [3:0]            i_ifid_pc_hi,
    input  logic                  i_stall,
    output logic [ADDR_W-1:0]     o_next_pc_c,
    output logic                  o_redirect_c,
    output logic                  o_flush_c,
    output logic                  o_hold_c
);

    pc_sel_e w_sel;

    // A stalled jump is dropped; ID re-presents it once the stall clears.
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_branch_taken) begin
            w_sel = SEL_BRANCH;
        end else if (i_jump && !i_stall) begin
            w_sel = SEL_JUMP;
        end else if (i_stall) begin
            w_sel = SEL_HOLD;
        end
    end

    // Decode selection into next PC and IF/ID control
    always_comb begin
        o_next_pc_c  = i_pc_plus4;
        o_redirect_c = 1'b0;
        o_flush_c    = 1'b0;
        o_hold_c     = 1'b0;
        unique case (w_sel)
            SEL_BRANCH: begin
                o_next_pc_c  = {i_branch_target, 2'b00};
                o_redirect_c = 1'b1;
                o_flush_c    = 1'b1;
            end
            SEL_JUMP: begin
                o_next_pc_c  = jump_target(i_ifid_pc_hi, i_jump_index);
                o_redirect_c = 1'b1;
                o_flush_c    = 1'b1;
            end
            SEL_HOLD: begin
                o_next_pc_c = i_pc;
                o_hold_c    = 1'b1;
            end
            SEL_SEQ: begin
                o_next_pc_c = i_pc_plus4;
            end
        endcase
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, sticky
// misaligned-redirect flag and saturating redirect counter.
// Ports:
//   Clk   rising-edge clock
//   Rst   asynchronous active-low reset
//   bus   fetch-stage interface (slave side): controls and imem data in;
//         ImemAddr/PC, IF/ID contents, Misaligned, RedirectCount out
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [INSTR_W-1:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int unsigned        CNT_W     = CNT_W_DEF
)(
    input  logic                Clk,
    input  logic                Rst,
    if_fetch_stage_if.slave     bus
);

    logic [ADDR_W-1:0] r_pc;
    ifid_t             r_ifid;
    logic              r_misaligned;
    logic [CNT_W-1:0]  r_redirect_cnt;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_redirect;
    logic              w_flush;
    logic              w_hold;

    // Wraps modulo 2^32 silently
    assign w_pc_plus4 = r_pc + 32'd4;

    next_pc_mux u_next_pc_mux (
        .i_pc            (r_pc),
        .i_pc_plus4      (w_pc_plus4),
        .i_branch_taken  (bus.BranchTaken),
        .i_branch_target (bus.BranchTarget[ADDR_W-1:2]),
        .i_jump          (bus.Jump),
        .i_jump_index    (bus.JumpIndex),
        .i_ifid_pc_hi    (r_ifid.pc_plus4[ADDR_W-1:ADDR_W-4]),
        .i_stall         (bus.Stall),
        .o_next_pc_c     (w_next_pc),
        .o_redirect_c    (w_redirect),
        .o_flush_c       (w_flush),
        .o_hold_c        (w_hold)
    );

    // PC register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register; imem data only sampled on a sequential fetch
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ifid <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
        end else if (w_flush) begin
            r_ifid.instr <= NOP_INSTR;
            r_ifid.valid <= 1'b0;
        end else if (!w_hold) begin
            r_ifid <= '{instr: bus.ImemRdata, pc_plus4: w_pc_plus4, valid: 1'b1};
        end
    end

    // Sticky flag: only branch targets can be misaligned
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_misaligned <= 1'b0;
        end else if (bus.BranchTaken && (bus.BranchTarget[1:0] != 2'b00)) begin
            r_misaligned <= 1'b1;
        end
    end

    // Saturating redirect counter, at most one step per cycle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_redirect_cnt <= '0;
        end else if (w_redirect && (r_redirect_cnt != {CNT_W{1'b1}})) begin
            r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        end
    end

    assign bus.ImemAddr      = r_pc;
    assign bus.PC            = r_pc;
    assign bus.IfIdInstr     = r_ifid.instr;
    assign bus.IfIdPcPlus4   = r_ifid.pc_plus4;
    assign bus.IfIdValid     = r_ifid.valid;
    assign bus.Misaligned    = r_misaligned;
    assign bus.RedirectCount = r_redirect_cnt;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, next-PC selection, and the IF/ID pipeline register.
- Consumes the branch-taken decision (Branch AND Zero) produced by the branch gate in EX/MEM, the jump request from ID, and the stall from the hazard unit.
- Drives the instruction-memory address and presents the fetched instruction to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction injected into IF/ID on flush (sll $0,$0,0).
- CNT_W, 16, width of the saturating redirect counter.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- BranchTaken  input  1  branch gate output (Branch & Zero), already aligned to EX/MEM.
- BranchTarget  input  32  branch target address from EX/MEM.
- Jump  input  1  jump decoded in ID.
- JumpIndex  input  26  instr[25:0] of the jump in ID.
- Stall  input  1  load-use stall from hazard unit.
- ImemRdata  input  32  instruction memory read data; combinational from ImemAddr.
- ImemAddr  output  32  fetch address; equals PC.
- PC  output  32  current program counter.
- IfIdInstr  output  32  IF/ID instruction.
- IfIdPcPlus4  output  32  IF/ID PC+4.
- IfIdValid  output  1  IF/ID holds a real, non-squashed instruction.
- Misaligned  output  1  sticky flag: a redirect target had bits [1:0] != 0.
- RedirectCount  output  CNT_W  saturating count of taken branches plus jumps.

Behaviour:
- Reset (Rst=0, asynchronous, any cycle including mid-redirect or mid-stall):
  - PC = RESET_PC, IfIdInstr = NOP_INSTR, IfIdPcPlus4 = 0.
  - IfIdValid = 0, Misaligned = 0, RedirectCount = 0.
- First fetch is in the first rising edge after Rst deasserts. IfIdValid=1 one cycle after that.
- pc_plus4 = PC + 4, 32-bit modulo. 32'hFFFF_FFFC wraps to 0 with no flag.
- Jump target = {IfIdPcPlus4[31:28], JumpIndex, 2'b00}.
- Next-state priority per rising edge, highest first:
  1. BranchTaken=1:
     - PC <= {BranchTarget[31:2], 2'b00}.
     - IF/ID <= NOP_INSTR, IfIdValid <= 0.
     - Overrides Jump and Stall in the same cycle.
  2. Jump=1 (Stall=0):
     - PC <= jump target.
     - IF/ID <= NOP_INSTR, IfIdValid <= 0 (one-slot squash).
  3. Stall=1:
     - PC holds; IfIdInstr, IfIdPcPlus4 and IfIdValid hold.
     - Jump with Stall and no branch: jump is ignored this cycle and is re-presented by ID on the next cycle.
  4. Otherwise:
     - PC <= pc_plus4.
     - IfIdInstr <= ImemRdata, IfIdPcPlus4 <= pc_plus4, IfIdValid <= 1.
- Misaligned:
  - Set on a taken branch when BranchTarget[1:0] != 0.
  - Never set by a jump, whose target is aligned by construction.
  - Cleared only by reset.
- RedirectCount:
  - +1 on each edge where case 1 or case 2 is taken.
  - Saturates at all-ones.
  - One increment per cycle maximum, even with branch and jump together.
- Back-to-back branches on consecutive cycles: each redirects and flushes; the last one wins.
- Latency: ImemAddr is valid in the same cycle as PC. Instruction reaches IfIdInstr one cycle later.
- No X propagation: ImemRdata is only sampled in case 4.
- All registers use non-blocking assignment and one always block per register group.

Decomposition:
- Shared package mips_pkg:
  - NOP_INSTR.
  - RESET_PC default.
  - Instruction width 32.
  - JUMP_IDX_W=26.
- One natural sub-module: next_pc_mux.
  - Combinational priority select and jump-target formation.
  - Produces next_pc, take_redirect and flush_ifid.
- if_fetch_stage holds the PC, IF/ID, flag and counter registers.

Test Plan:
1. Reset then free-run, ImemRdata=addr-tagged words:
   - PC = 0, 4, 8, 12 on successive edges.
   - IfIdInstr lags by one cycle; IfIdValid=1 from cycle 2.
2. At PC=0x10, BranchTaken=1, BranchTarget=0x100:
   - Next PC=0x100, IfIdInstr=0, IfIdValid=0, RedirectCount=1.
   - Following cycle fetches 0x100.
3. Stall=1 for 3 cycles at PC=0x20:
   - PC stays 0x20 and IF/ID is unchanged for 3 edges.
   - PC resumes at 0x24 after Stall drops.
4. Branch, Stall and Jump all asserted together, BranchTarget=0x203:
   - PC=0x200, Misaligned=1, RedirectCount increments by exactly 1, IfIdValid=0.
5. Jump=1, JumpIndex=26'h0000040, IfIdPcPlus4=0x9000_0004:
   - PC=0x9000_0100, IF/ID squashed.
6. Rst pulsed low asynchronously mid-stall with RedirectCount=5:
   - All outputs return to reset values immediately, without waiting for a clock edge.
   - Fetch restarts at RESET_PC.
   - Separately, force RedirectCount to all-ones and redirect again: value stays all-ones.
